// File: rtl/pc_fetch_unit_pkg.sv
// Shared encodings for the PC fetch unit: next-PC selects, FSM states and reset PC.
package pc_fetch_unit_pkg;

   typedef enum logic [1:0] {
      PC_SEQ = 2'b00,
      PC_BR  = 2'b01,
      PC_JMP = 2'b10
   } pcsrc_e;

   typedef enum logic {
      ST_FETCH = 1'b0,
      ST_EXEC  = 1'b1
   } state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Word offset of a branch: sign-extended {imm, 2'b00}
   function automatic logic [31:0] branch_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/pc_fetch_unit_npc_mux.sv
// Combinational next-PC selection: sequential, PC-relative branch or region jump.
module npc_mux
   import pc_fetch_unit_pkg::*;
(
   input  logic [31:0] Pc4,
   input  logic [15:0] Imm,
   input  logic [25:0] Jaddr,
   input  logic [1:0]  Pcsrc,
   output logic [31:0] npc
);

   // Select the next PC; the unused 2'b11 code falls through to jump
   always_comb begin
      npc = Pc4;
      case (pcsrc_e'(Pcsrc))
         PC_SEQ:  npc = Pc4;
         PC_BR:   npc = Pc4 + branch_offset(Imm);
         PC_JMP:  npc = {Pc4[31:28], Jaddr, 2'b00};
         default: npc = {Pc4[31:28], Jaddr, 2'b00};
      endcase
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// Two-state fetch/execute sequencer holding the PC and the current instruction word.
module pc_fetch_unit
   import pc_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        Clk,
   input  logic        Clrn,
   input  logic [1:0]  Pcsrc,
   input  logic [15:0] Imm,
   input  logic [25:0] Jaddr,
   input  logic        Stall,
   output logic        Imem_req,
   output logic [31:0] Imem_addr,
   input  logic        Imem_ack,
   input  logic [31:0] Imem_rdata,
   output logic [31:0] Inst,
   output logic        Inst_valid,
   output logic [31:0] Pc,
   output logic [31:0] Pc4
);

   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] pc4_s;
   logic [31:0] npc_s;

   assign pc4_s = pc_q + 32'd4;

   npc_mux u_npc_mux (
      .Pc4   (pc4_s),
      .Imm   (Imm),
      .Jaddr (Jaddr),
      .Pcsrc (Pcsrc),
      .npc   (npc_s)
   );

   // Next-state logic: capture on ack in FETCH, advance the PC when EXEC is not stalled
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      case (state_q)
         ST_FETCH: begin
            if (Imem_ack) begin
               inst_d  = Imem_rdata;
               state_d = ST_EXEC;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_EXEC: begin
            if (!Stall) begin
               pc_d    = npc_s;
               state_d = ST_FETCH;
            end else begin
               state_d = ST_EXEC;
            end
         end
         default: state_d = ST_FETCH;
      endcase
   end

   // State registers; reset wins over stall and ack
   always_ff @(posedge Clk) begin
      if (!Clrn) begin
         state_q <= ST_FETCH;
         pc_q    <= RESET_PC_ALIGNED;
         inst_q  <= 32'h0000_0000;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
      end
   end

   assign Imem_req   = (state_q == ST_FETCH);
   assign Inst_valid = (state_q == ST_EXEC);
   assign Imem_addr  = pc_q;
   assign Pc         = pc_q;
   assign Pc4        = pc4_s;
   assign Inst       = inst_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: two instances (reset PC 0 and a misaligned high reset PC) against a behavioural model.
module tb_pc_fetch_unit;

   logic        Clk = 1'b0;
   logic        Clrn = 1'b0;
   logic [1:0]  Pcsrc = 2'b00;
   logic [15:0] Imm = 16'h0000;
   logic [25:0] Jaddr = 26'h0;
   logic        Stall = 1'b0;
   logic        Imem_ack = 1'b0;
   logic [31:0] Imem_rdata = 32'h0;

   logic        req   [2];
   logic [31:0] addr  [2];
   logic [31:0] inst  [2];
   logic        valid [2];
   logic [31:0] pc    [2];
   logic [31:0] pc4   [2];

   int n_checks = 0;
   int n_errors = 0;

   always #5 Clk = ~Clk;

   pc_fetch_unit u_dut0 (
      .Clk(Clk), .Clrn(Clrn), .Pcsrc(Pcsrc), .Imm(Imm), .Jaddr(Jaddr), .Stall(Stall),
      .Imem_req(req[0]), .Imem_addr(addr[0]), .Imem_ack(Imem_ack), .Imem_rdata(Imem_rdata),
      .Inst(inst[0]), .Inst_valid(valid[0]), .Pc(pc[0]), .Pc4(pc4[0])
   );

   pc_fetch_unit #(.RESET_PC(32'h4000_000B)) u_dut1 (
      .Clk(Clk), .Clrn(Clrn), .Pcsrc(Pcsrc), .Imm(Imm), .Jaddr(Jaddr), .Stall(Stall),
      .Imem_req(req[1]), .Imem_addr(addr[1]), .Imem_ack(Imem_ack), .Imem_rdata(Imem_rdata),
      .Inst(inst[1]), .Inst_valid(valid[1]), .Pc(pc[1]), .Pc4(pc4[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: one instruction is either awaiting memory or executing
   logic [31:0] m_pc [2];
   logic [31:0] m_inst = 32'h0;
   bit          m_executing = 1'b0;
   bit          m_started = 1'b0;
   logic [31:0] m_reset_pc [2] = '{32'h0000_0000, 32'h4000_0008};

   function automatic logic [31:0] target(input logic [31:0] cur, input logic [1:0] src,
                                          input logic [15:0] imm, input logic [25:0] ja);
      logic [31:0] seq;
      seq = cur + 32'd4;
      if (src == 2'b00) return seq;
      if (src == 2'b01) return seq + 32'($signed(imm)) * 32'd4;
      return (seq & 32'hF000_0000) | ({6'b0, ja} << 2);
   endfunction

   always @(posedge Clk) begin
      if (!Clrn) begin
         for (int k = 0; k < 2; k++) m_pc[k] = m_reset_pc[k];
         m_inst      = 32'h0;
         m_executing = 1'b0;
         m_started   = 1'b1;
      end else if (!m_executing) begin
         if (Imem_ack) begin
            m_inst      = Imem_rdata;
            m_executing = 1'b1;
         end
      end else if (!Stall) begin
         for (int k = 0; k < 2; k++) m_pc[k] = target(m_pc[k], Pcsrc, Imm, Jaddr);
         m_executing = 1'b0;
      end
   end

   always @(negedge Clk) begin
      if (m_started) begin
         for (int k = 0; k < 2; k++) begin
            check("req",   {31'b0, req[k]},   {31'b0, !m_executing});
            check("valid", {31'b0, valid[k]}, {31'b0, m_executing});
            check("addr",  addr[k], m_pc[k]);
            check("pc",    pc[k],   m_pc[k]);
            check("pc4",   pc4[k],  m_pc[k] + 32'd4);
            check("inst",  inst[k], m_inst);
         end
      end
   end

   task automatic tick();
      @(posedge Clk);
      @(negedge Clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      Clrn = 1'b0; Stall = 1'b1; Imem_ack = 1'b1; Imem_rdata = 32'hDEAD_BEEF;
      for (int i = 0; i < n; i++) tick();
      check("rst_pc0",   pc[0], 32'h0000_0000);
      check("rst_pc1",   pc[1], 32'h4000_0008);
      check("rst_inst",  inst[0], 32'h0000_0000);
      check("rst_valid", {31'b0, valid[0]}, 32'd0);
      check("rst_req",   {31'b0, req[0]}, 32'd1);
      Clrn = 1'b1; Stall = 1'b0; Imem_ack = 1'b0;
   endtask

   task automatic fetch(input int delay, input logic [31:0] data);
      for (int i = 0; i < delay; i++) begin
         Imem_ack = 1'b0; Imem_rdata = $urandom;
         check("wait_req",   {31'b0, req[0]},   32'd1);
         check("wait_valid", {31'b0, valid[0]}, 32'd0);
         tick();
      end
      Imem_ack = 1'b1; Imem_rdata = data;
      check("ack_req", {31'b0, req[0]}, 32'd1);
      tick();
      Imem_ack = 1'b0;
      check("exec_valid", {31'b0, valid[0]}, 32'd1);
      check("exec_inst",  inst[0], data);
   endtask

   task automatic exec(input int stalls, input logic [1:0] src, input logic [15:0] imm,
                       input logic [25:0] ja);
      for (int i = 0; i < stalls; i++) begin
         Stall = 1'b1; Pcsrc = 2'($urandom); Imm = 16'($urandom); Jaddr = 26'($urandom);
         Imem_ack = 1'b1; Imem_rdata = $urandom;
         tick();
         check("stall_req", {31'b0, req[0]}, 32'd0);
      end
      Stall = 1'b0; Imem_ack = 1'b0; Pcsrc = src; Imm = imm; Jaddr = ja;
      tick();
      Pcsrc = 2'($urandom); Imm = 16'($urandom); Jaddr = 26'($urandom);
   endtask

   initial begin
      tick();
      do_reset(2);
      // First instruction with ack on the first request cycle
      fetch(0, 32'h2008_0005);
      check("first_pc", pc[0], 32'h0000_0000);
      exec(0, 2'b00, 16'h0, 26'h0);
      check("seq_addr0", addr[0], 32'h0000_0004);
      check("seq_addr1", addr[1], 32'h4000_000C);

      // Jump in the high region, codes 10 and 11
      do_reset(1);
      fetch(0, 32'h0800_0100);
      exec(0, 2'b10, 16'h0, 26'h000_0100);
      check("jmp_addr1", addr[1], 32'h4000_0400);
      check("jmp_addr0", addr[0], 32'h0000_0400);
      do_reset(1);
      fetch(0, 32'h0800_0100);
      exec(0, 2'b11, 16'h0, 26'h000_0100);
      check("jmp11_addr1", addr[1], 32'h4000_0400);

      // Branches from Pc=0x10
      do_reset(1);
      fetch(0, 32'h0800_0004);
      exec(0, 2'b10, 16'h0, 26'h000_0004);
      check("to_0x10", addr[0], 32'h0000_0010);
      fetch(0, 32'h1000_FFFE);
      exec(0, 2'b01, 16'hFFFE, 26'h0);
      check("br_back", addr[0], 32'h0000_000C);
      fetch(0, 32'h0000_0020);
      exec(0, 2'b00, 16'h0, 26'h0);
      fetch(0, 32'h1000_0003);
      exec(0, 2'b01, 16'h0003, 26'h0);
      check("br_fwd", addr[0], 32'h0000_0020);

      // Delayed ack, then a long stall with ack and select noise
      fetch(3, 32'hAABB_CCDD);
      exec(5, 2'b00, 16'h0, 26'h0);
      check("after_stall", addr[0], 32'h0000_0024);
      check("after_stall_inst", inst[0], 32'hAABB_CCDD);

      // Wrap of the PC at the top of the address space
      do_reset(1);
      fetch(0, 32'h1000_FFFE);
      exec(0, 2'b01, 16'hFFFE, 26'h0);
      check("to_top", addr[0], 32'hFFFF_FFFC);
      fetch(1, 32'h0000_0000);
      check("top_pc4", pc4[0], 32'h0000_0000);
      exec(0, 2'b00, 16'h0, 26'h0);
      check("wrap", addr[0], 32'h0000_0000);

      // Reset while a fetch is pending, then while stalled in EXEC
      fetch(0, 32'h0800_0040);
      exec(0, 2'b10, 16'h0, 26'h000_0040);
      Imem_ack = 1'b0;
      tick();
      tick();
      do_reset(1);
      check("rst_pend0", addr[0], 32'h0000_0000);
      check("rst_pend1", addr[1], 32'h4000_0008);
      fetch(0, 32'h1234_5678);
      do_reset(1);
      check("rst_exec_valid", {31'b0, valid[0]}, 32'd0);

      // Random traffic checked by the model alone
      for (int i = 0; i < 200; i++) begin
         Clrn = ($urandom_range(0, 29) != 0);
         Stall = ($urandom_range(0, 2) == 0);
         Imem_ack = 1'($urandom);
         Imem_rdata = $urandom;
         Pcsrc = 2'($urandom); Imm = 16'($urandom); Jaddr = 26'($urandom);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset; bits [1:0] are forced to 0.
REQ-003 Clk  in  1  rising-edge clock for all state.
REQ-004 Clrn  in  1  synchronous active-low reset.
REQ-005 Pcsrc  in  2  next-PC select from control unit: 00 PC+4, 01 branch, 10 jump, 11 treated as jump.
REQ-006 Imm  in  16  branch offset field of the current instruction.
REQ-007 Jaddr  in  26  jump target field of the current instruction.
REQ-008 Stall  in  1  decode/execute hold; freezes the current instruction.
REQ-009 Imem_req  out  1  instruction-memory read request.
REQ-010 Imem_addr  out  32  word-aligned fetch address, equal to Pc.
REQ-011 Imem_ack  in  1  memory returns Imem_rdata this cycle.
REQ-012 Imem_rdata  in  32  instruction word.
REQ-013 Inst  out  32  registered current instruction (Op=Inst[31:26], Func=Inst[5:0]).
REQ-014 Inst_valid  out  1  Inst is valid and its control outputs may be acted on.
REQ-015 Pc  out  32  address of the current instruction.
REQ-016 Pc4  out  32  Pc+4.

Function
REQ-017 SHALL implement a two-state FSM: FETCH and EXEC.
REQ-018 In FETCH: Imem_req=1, Imem_addr=Pc held stable until Imem_ack; Inst_valid=0.
REQ-019 In FETCH with Imem_ack=1: Inst<=Imem_rdata, next state EXEC; request deasserts the following cycle.
REQ-020 In EXEC: Imem_req=0, Inst_valid=1; Imem_ack is ignored.
REQ-021 In EXEC with Stall=1: Pc, Inst and state hold.
REQ-022 In EXEC with Stall=0: Pc<=next PC, state<=FETCH; Pcsrc, Imm and Jaddr are sampled only in this cycle.
REQ-023 Minimum throughput: one instruction per 2 cycles (ack in the same cycle as the request).
REQ-024 Pc4 = Pc+4 modulo 2^32; 32'hFFFF_FFFC wraps to 0.
REQ-025 Branch target = Pc4 + sign-extended {Imm,2'b00}, modulo 2^32.
REQ-026 Jump target = {Pc4[31:28], Jaddr, 2'b00}.
REQ-027 Pc[1:0] SHALL always be 00.
REQ-028 Inst holds its last value in FETCH; only Inst_valid qualifies it.

Reset
REQ-029 On Clrn=0 at a rising edge: Pc<=RESET_PC, Inst<=0, state<=FETCH, Inst_valid=0.
REQ-030 Imem_req SHALL be asserted the first cycle after reset release.
REQ-031 Reset during an outstanding fetch abandons the fetch; the instruction memory shares Clrn, so no stale ack follows.
REQ-032 Reset overrides Stall and Imem_ack in the same cycle.

Structure
REQ-033 A shared package SHALL hold the Pcsrc encodings (PC_SEQ, PC_BR, PC_JMP), the FSM state encodings and the RESET_PC default.
REQ-034 Next-PC computation SHALL be a combinational sub-module npc_mux (inputs Pc4, Imm, Jaddr, Pcsrc; output npc).
REQ-035 All registers SHALL be clocked by Clk only; there is no combinational path from Imem_rdata to any output.

Verification
REQ-036 Reset release, ack on first cycle, data 32'h2008_0005, Pcsrc=00 -> Inst_valid high in cycle 2 with Inst=32'h2008_0005; next Imem_addr=32'h0000_0004.
REQ-037 Pc=32'h0000_0010, Pcsrc=01, Imm=16'hFFFE -> next Imem_addr=32'h0000_000C; with Imm=16'h0003 -> 32'h0000_0020.
REQ-038 Pc=32'h4000_0008, Pcsrc=10, Jaddr=26'h000_0100 -> next Imem_addr=32'h4000_0400; Pcsrc=11 gives the same result.
REQ-039 Ack delayed 3 cycles -> Imem_req and Imem_addr stable for 4 cycles; Inst_valid=0 throughout; exactly one EXEC follows.
REQ-040 Stall=1 for 5 EXEC cycles -> Pc and Inst unchanged and no request; Stall=0 -> fetch of the next PC.
REQ-041 Pc=32'hFFFF_FFFC, Pcsrc=00 -> next Imem_addr=32'h0000_0000; Clrn=0 during a pending fetch -> Imem_addr=RESET_PC after release.
